// File: rtl/mem_pkg.sv
// Shared types for the memory stage: FSM states, access sizes and op3 decode.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mem_state_t;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } mem_size_t;

  localparam logic [1:0] OP_MEM = 2'd3;

  localparam logic [5:0] OP3_LD   = 6'h00;
  localparam logic [5:0] OP3_LDUB = 6'h01;
  localparam logic [5:0] OP3_LDUH = 6'h02;
  localparam logic [5:0] OP3_ST   = 6'h04;
  localparam logic [5:0] OP3_STB  = 6'h05;
  localparam logic [5:0] OP3_STH  = 6'h06;
  localparam logic [5:0] OP3_LDSB = 6'h09;
  localparam logic [5:0] OP3_LDSH = 6'h0A;

  typedef struct packed {
    mem_size_t size;
    logic      sgn;
    logic      we;
    logic      ok;
  } op3_info_t;

  function automatic op3_info_t op3_decode(
    input logic [5:0] op3
  );
    op3_info_t d;
    d = '{WORD, 1'b0, 1'b0, 1'b0};
    case (op3)
      OP3_LD:   d = '{WORD, 1'b0, 1'b0, 1'b1};
      OP3_LDUB: d = '{BYTE, 1'b0, 1'b0, 1'b1};
      OP3_LDUH: d = '{HALF, 1'b0, 1'b0, 1'b1};
      OP3_ST:   d = '{WORD, 1'b0, 1'b1, 1'b1};
      OP3_STB:  d = '{BYTE, 1'b0, 1'b1, 1'b1};
      OP3_STH:  d = '{HALF, 1'b0, 1'b1, 1'b1};
      OP3_LDSB: d = '{BYTE, 1'b1, 1'b0, 1'b1};
      OP3_LDSH: d = '{HALF, 1'b1, 1'b0, 1'b1};
      default:  d = '{WORD, 1'b0, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: store replication + byte enables, load extract
// with zero/sign extension. Offset is truncated to natural alignment here.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    unique case (off)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    be      = 4'b0000;
    wdata   = '0;
    ld_data = '0;
    case (size)
      BYTE: begin
        be      = 4'b1000 >> off;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sgn & b[7]}}, b};
      end
      HALF: begin
        be      = 4'b1100 >> {off[1], 1'b0};
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sgn & h[15]}}, h};
      end
      WORD: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = rdata;
      end
      default: begin
        be      = 4'b0000;
        wdata   = '0;
        ld_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// SPARC V8 memory stage: single-outstanding load/store bus master.
// MEM_STAGE_ALIGN_CHECK_EN traps misaligned half/word accesses.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe_mem,
  input  logic [1:0]        opcode,
  input  logic [5:0]        op3,
  input  logic [ADDR_W-1:0] result,
  input  logic [DATA_W-1:0] st_data,
  input  logic [4:0]        rd,
  output logic              mem_blocked,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_align_err
);

  if (DATA_W != 32) begin : g_bad_dw
    $error("mem_stage: DATA_W must be 32");
  end

  mem_state_t state;
  mem_state_t state_nx;
  op3_info_t  dec;
  mem_size_t  size_q;
  mem_size_t  l_size;
  logic       sgn_q;
  logic       we_q;
  logic [1:0] off_q;
  logic [1:0] l_off;
  logic [4:0] rd_q;
  logic       idle;
  logic       is_mem;
  logic       acc_mem;
  logic       acc_alu;
  logic       misal;
  logic       bad;
  logic [3:0]  l_be;
  logic [31:0] l_wdata;
  logic [31:0] l_ld;

  assign dec     = op3_decode(op3);
  assign idle    = (state == IDLE);
  assign is_mem  = exe_mem & (opcode == OP_MEM);
  assign acc_mem = idle & is_mem;
  assign acc_alu = idle & exe_mem & (opcode != OP_MEM);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign misal = ((dec.size == HALF) & result[0])
               | ((dec.size == WORD) & (|result[1:0]));
`else
  assign misal = 1'b0;
`endif

  assign bad = ~dec.ok | misal;

  // Lanes see the incoming op at accept, the latched op while loading.
  assign l_size = idle ? dec.size : size_q;
  assign l_off  = idle ? result[1:0] : off_q;

  mem_lane_align u_lane (
    .size    (l_size),
    .sgn     (sgn_q),
    .off     (l_off),
    .st_data (st_data),
    .rdata   (bus_rdata),
    .be      (l_be),
    .wdata   (l_wdata),
    .ld_data (l_ld)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (acc_mem) state_nx = bad ? DONE : REQ;
      REQ:     if (bus_gnt) state_nx = WAIT;
      WAIT:    if (bus_rvalid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // DONE drops the stall so the ALU advances exactly once.
  always_comb begin
    mem_blocked = acc_mem | (state == REQ) | (state == WAIT);
    bus_req     = (state == REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_wdata <= '0;
      size_q    <= BYTE;
      sgn_q     <= 1'b0;
      we_q      <= 1'b0;
      off_q     <= '0;
      rd_q      <= '0;
    end else begin
      wb_valid <= acc_alu | (state_nx == DONE);
      if (acc_alu) begin
        wb_rd   <= rd;
        wb_data <= result[DATA_W-1:0];
      end
      if (acc_mem) begin
        if (bad) begin
          wb_rd   <= '0;
          wb_data <= '0;
        end else begin
          bus_addr  <= {result[ADDR_W-1:2], 2'b00};
          bus_we    <= dec.we;
          bus_be    <= l_be;
          bus_wdata <= l_wdata;
          size_q    <= dec.size;
          sgn_q     <= dec.sgn;
          we_q      <= dec.we;
          off_q     <= result[1:0];
          rd_q      <= rd;
        end
      end
      if ((state == WAIT) && bus_rvalid) begin
        wb_rd   <= we_q ? 5'd0 : rd_q;
        wb_data <= we_q ? '0 : l_ld;
      end
    end
  end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) mem_align_err <= 1'b0;
    else       mem_align_err <= acc_mem & dec.ok & misal;
  end
`else
  assign mem_align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: byte-level load/store model, bus responder
// and a writeback scoreboard checked on every cycle.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_mem;
  logic [1:0]  opcode;
  logic [5:0]  op3;
  logic [63:0] result;
  logic [31:0] st_data;
  logic [4:0]  rd;
  logic        mem_blocked;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_align_err;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .exe_mem       (exe_mem),
    .opcode        (opcode),
    .op3           (op3),
    .result        (result),
    .st_data       (st_data),
    .rd            (rd),
    .mem_blocked   (mem_blocked),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_gnt       (bus_gnt),
    .bus_rvalid    (bus_rvalid),
    .bus_rdata     (bus_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_align_err (mem_align_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  opc;
    logic [5:0]  op3;
    logic [63:0] a;
    logic [31:0] st;
    logic [4:0]  rd;
    logic [31:0] rdat;
    int          gw;
    int          rw;
    logic [31:0] lit_data;
    logic [4:0]  lit_rd;
    logic [3:0]  lit_be;
    logic [31:0] lit_wd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [4:0]  lit_rd;
    logic [31:0] lit_data;
  } wb_t;

  wb_t  wbq[$];
  vec_t vecs[$];

  logic        exp_bus = 1'b0;
  logic [63:0] e_addr;
  logic        e_we;
  logic [3:0]  e_be, l_be;
  logic [31:0] e_wd, l_wd;
  int          gnt_wait = 0;
  int          rv_wait = 0;
  logic [31:0] rdata_v = '0;
  int          g_cnt = 0;
  int          r_cnt = 0;
  bit          pend = 0;

  // Access = n bytes at natural-aligned offset; big-endian byte k sits
  // at bits 31-8k..24-8k of the bus word.
  function automatic void model(
    input  vec_t        v,
    output wb_t         w,
    output logic        bus,
    output logic [63:0] ba,
    output logic [3:0]  be,
    output logic [31:0] wd,
    output int          blk
  );
    int n, off, mis;
    logic sg, we, ok;
    logic [63:0] m, val;
    n = 4; sg = 0; we = 0; ok = 1;
    case (v.op3)
      6'h00: n = 4;
      6'h01: n = 1;
      6'h02: n = 2;
      6'h04: begin n = 4; we = 1; end
      6'h05: begin n = 1; we = 1; end
      6'h06: begin n = 2; we = 1; end
      6'h09: begin n = 1; sg = 1; end
      6'h0A: begin n = 2; sg = 1; end
      default: ok = 0;
    endcase
    mis = int'(v.a[1:0]) % n;
    off = int'(v.a[1:0]) - mis;
`ifndef MEM_STAGE_ALIGN_CHECK_EN
    mis = 0;
`endif
    m = (64'd1 << (8 * n)) - 64'd1;
    w = '{5'd0, 32'd0, 1'b0, 5'd0, 32'd0};
    bus = 0; ba = '0; be = '0; wd = '0; blk = 0;
    if (v.opc != 2'd3) begin
      w.rd = v.rd;
      w.data = v.a[31:0];
    end else if (!ok || mis != 0) begin
      w.err = (mis != 0);
      blk = 1;
    end else begin
      bus = 1;
      ba = v.a & ~64'd3;
      blk = 3 + v.gw + v.rw;
      be = 4'(((1 << n) - 1) << (4 - n - off));
      if (we) begin
        for (int i = 0; i < 4; i += n)
          wd |= 32'((64'(v.st) & m) << (8 * i));
      end else begin
        val = (64'(v.rdat) >> (8 * (4 - n - off))) & m;
        if (sg && val[8*n-1]) val |= ~m;
        w.rd = v.rd;
        w.data = val[31:0];
      end
    end
  endfunction

  // Bus responder: grant after gnt_wait REQ cycles, respond rv_wait later.
  initial begin
    bus_gnt = 0;
    bus_rvalid = 0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_gnt = 0;
      bus_rvalid = 0;
      if (bus_req) begin
        if (!exp_bus) begin
          chk("bus_req_unexpected", bus_req, 0);
        end else begin
          chk("bus_addr", bus_addr, e_addr);
          chk("bus_we", bus_we, e_we);
          if (e_we) begin
            chk("bus_be", bus_be, e_be);
            chk("bus_wdata", bus_wdata, e_wd);
            chk("bus_be_lit", bus_be, l_be);
            chk("bus_wdata_lit", bus_wdata, l_wd);
          end
        end
        if (g_cnt == gnt_wait) begin
          bus_gnt = 1;
          g_cnt = 0;
          pend = 1;
          r_cnt = 0;
        end else begin
          g_cnt++;
        end
      end else if (pend) begin
        if (r_cnt == rv_wait) begin
          bus_rvalid = 1;
          bus_rdata = rdata_v;
          pend = 0;
        end else begin
          r_cnt++;
        end
      end
    end
  end

  // Writeback scoreboard.
  always @(negedge clk) begin
    wb_t e;
    if (!reset) begin
      if (wb_valid) begin
        if (wbq.size() == 0) begin
          chk("wb_unexpected", wb_valid, 0);
        end else begin
          e = wbq.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
          chk("mem_align_err", mem_align_err, e.err);
          chk("wb_rd_lit", wb_rd, e.lit_rd);
          chk("wb_data_lit", wb_data, e.lit_data);
        end
      end else if (mem_align_err) begin
        chk("align_err_stray", mem_align_err, 0);
      end
    end
  end

  // Entered and left just after a posedge.
  task automatic apply(input vec_t v);
    wb_t w;
    logic bus;
    int blk, exp_blk, k;
    model(v, w, bus, e_addr, e_be, e_wd, exp_blk);
    w.lit_rd = v.lit_rd;
    w.lit_data = v.lit_data;
    e_we = (v.op3[2] == 1'b1);
    l_be = v.lit_be;
    l_wd = v.lit_wd;
    exp_bus = bus;
    gnt_wait = v.gw;
    rv_wait = v.rw;
    rdata_v = v.rdat;
    exe_mem = 1;
    opcode = v.opc;
    op3 = v.op3;
    result = v.a;
    st_data = v.st;
    rd = v.rd;
    wbq.push_back(w);
    blk = 0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!mem_blocked) break;
      blk++;
    end
    if (k == 60) chk("timeout_mem_blocked", mem_blocked, 0);
    chk("mem_blocked_cycles", 64'(blk), 64'(exp_blk));
    if (v.opc == 2'd3) chk("done_wb_valid", wb_valid, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    exe_mem = 0;
    opcode = 0;
    op3 = 0;
    result = '0;
    st_data = '0;
    rd = '0;
    // opc op3 addr st rd rdata gw rw lit_data lit_rd lit_be lit_wd
    vecs.push_back('{2'd2, 6'h00, 64'h1234, 32'h0, 5'd5, 32'h0, 0, 0,
                     32'h1234, 5'd5, 4'h0, 32'h0});
    vecs.push_back('{2'd2, 6'h00, 64'hFFFF_FFFF_8765_4321, 32'h0, 5'd6,
                     32'h0, 0, 0, 32'h8765_4321, 5'd6, 4'h0, 32'h0});
    vecs.push_back('{2'd3, 6'h09, 64'h1003, 32'h0, 5'd7, 32'h0000_00F0,
                     0, 2, 32'hFFFF_FFF0, 5'd7, 4'h0, 32'h0});
    vecs.push_back('{2'd3, 6'h06, 64'h2002, 32'h0000_ABCD, 5'd9, 32'h0,
                     0, 0, 32'h0, 5'd0, 4'b0011, 32'hABCD_ABCD});
    vecs.push_back('{2'd3, 6'h02, 64'h4006, 32'h0, 5'd3, 32'h1234_8765,
                     5, 1, 32'h0000_8765, 5'd3, 4'h0, 32'h0});
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    vecs.push_back('{2'd3, 6'h00, 64'h3001, 32'h0, 5'd4, 32'hCAFE_BABE,
                     0, 0, 32'h0, 5'd0, 4'h0, 32'h0});
    vecs.push_back('{2'd3, 6'h0A, 64'h6003, 32'h0, 5'd14, 32'h0000_F00D,
                     0, 0, 32'h0, 5'd0, 4'h0, 32'h0});
`else
    vecs.push_back('{2'd3, 6'h00, 64'h3001, 32'h0, 5'd4, 32'hCAFE_BABE,
                     0, 0, 32'hCAFE_BABE, 5'd4, 4'h0, 32'h0});
    vecs.push_back('{2'd3, 6'h0A, 64'h6003, 32'h0, 5'd14, 32'h0000_F00D,
                     0, 0, 32'hFFFF_F00D, 5'd14, 4'h0, 32'h0});
`endif
    vecs.push_back('{2'd3, 6'h01, 64'h5002, 32'h0, 5'd10, 32'h1122_3344,
                     1, 0, 32'h0000_0033, 5'd10, 4'h0, 32'h0});
    vecs.push_back('{2'd3, 6'h0A, 64'h6000, 32'h0, 5'd11, 32'h8001_0000,
                     0, 0, 32'hFFFF_8001, 5'd11, 4'h0, 32'h0});
    vecs.push_back('{2'd3, 6'h05, 64'h7001, 32'h1234_565A, 5'd12, 32'h0,
                     0, 0, 32'h0, 5'd0, 4'b0100, 32'h5A5A_5A5A});
    vecs.push_back('{2'd3, 6'h04, 64'hFFFF_0000_0000_8000, 32'hDEAD_BEEF,
                     5'd2, 32'h0, 2, 0, 32'h0, 5'd0, 4'b1111,
                     32'hDEAD_BEEF});
    vecs.push_back('{2'd3, 6'h03, 64'h8008, 32'h0, 5'd13, 32'h0,
                     0, 0, 32'h0, 5'd0, 4'h0, 32'h0});
    vecs.push_back('{2'd0, 6'h00, 64'h42, 32'h0, 5'd1, 32'h0,
                     0, 0, 32'h42, 5'd1, 4'h0, 32'h0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_align_err", mem_align_err, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_mem_blocked", mem_blocked, 0);
    @(posedge clk);
    #1;
    reset = 0;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset in WAIT with the response arriving afterwards.
    exp_bus = 1;
    e_addr = 64'h9000;
    e_we = 0;
    gnt_wait = 0;
    rv_wait = 3;
    rdata_v = 32'h55;
    exe_mem = 1;
    opcode = 2'd3;
    op3 = 6'h00;
    result = 64'h9000;
    rd = 5'd8;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("wait_blocked", mem_blocked, 1);
    reset = 1;
    exe_mem = 0;
    @(posedge clk);
    #1;
    reset = 0;
    exp_bus = 0;
    chk("post_rst_bus_req", bus_req, 0);
    chk("post_rst_blocked", mem_blocked, 0);
    chk("post_rst_wb_valid", wb_valid, 0);
    repeat (6) @(negedge clk);
    chk("late_rvalid_bus_req", bus_req, 0);
    @(posedge clk);
    #1;
    apply('{2'd3, 6'h01, 64'hA001, 32'h0, 5'd15, 32'h00AB_0000,
            0, 0, 32'h0000_00AB, 5'd15, 4'h0, 32'h0});

    exe_mem = 0;
    repeat (5) @(negedge clk);
    chk("wbq_drained", 64'(wbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
